// File: rtl/vlog_word_checker.sv
// rtl/vlog_word_checker.sv - receive-side checker for a fixed sequence of words
// Accepts NWORDS words over valid/ready, compares each with 4-state equality, reports pass/timeout.
module vlog_word_checker #(
    parameter int WIDTH   = 32,
    parameter int NWORDS  = 3,
    parameter int EXP0    = 42,
    parameter int EXP1    = 66,
    parameter int EXP2    = 77,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             done,
    output logic             passed,
    output logic             timed_out,
    output logic [7:0]       err_count,
    output logic [1:0]       word_idx,
    output logic [WIDTH-1:0] last_data
);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic {S_WAIT = 1'b0, S_DONE = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              passed_q, passed_d;
    logic              timed_out_q, timed_out_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [1:0]        word_idx_q, word_idx_d;
    logic [WIDTH-1:0]  last_data_q, last_data_d;
    logic [CW-1:0]     idle_q, idle_d;
    logic [WIDTH-1:0]  exp_word;
    logic              xfer;

    always_comb begin
        exp_word = WIDTH'(EXP0);
        case (word_idx_q)
            2'd1:    exp_word = WIDTH'(EXP1);
            2'd2:    exp_word = WIDTH'(EXP2);
            default: exp_word = WIDTH'(EXP0);
        endcase
    end

    assign xfer = in_valid && in_ready_q;

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        done_d      = done_q;
        passed_d    = passed_q;
        timed_out_d = timed_out_q;
        err_count_d = err_count_q;
        word_idx_d  = word_idx_q;
        last_data_d = last_data_q;
        idle_d      = idle_q;
        case (state_q)
            S_WAIT: begin
                in_ready_d = 1'b1;
                if (xfer) begin
                    last_data_d = in_data;
                    word_idx_d  = word_idx_q + 2'd1;
                    idle_d      = '0;
                    // !== so that any X/Z bit on the bus counts as a mismatch
                    if ((in_data !== exp_word) && (err_count_q != 8'hFF))
                        err_count_d = err_count_q + 8'd1;
                    if (word_idx_q == 2'(NWORDS - 1)) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        in_ready_d = 1'b0;
                        passed_d   = (err_count_d == 8'd0);
                    end
                end else if (TIMEOUT != 0) begin
                    idle_d = idle_q + 1'b1;
                    if (idle_d == CW'(TIMEOUT)) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        timed_out_d = 1'b1;
                        passed_d    = 1'b0;
                        in_ready_d  = 1'b0;
                    end
                end
            end
            default: begin
                in_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT;
            in_ready_q  <= 1'b0;
            done_q      <= 1'b0;
            passed_q    <= 1'b0;
            timed_out_q <= 1'b0;
            err_count_q <= 8'd0;
            word_idx_q  <= 2'd0;
            last_data_q <= '0;
            idle_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
            passed_q    <= passed_d;
            timed_out_q <= timed_out_d;
            err_count_q <= err_count_d;
            word_idx_q  <= word_idx_d;
            last_data_q <= last_data_d;
            idle_q      <= idle_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign done      = done_q;
    assign passed    = passed_q;
    assign timed_out = timed_out_q;
    assign err_count = err_count_q;
    assign word_idx  = word_idx_q;
    assign last_data = last_data_q;
endmodule

// File: tb/tb_vlog_word_checker.sv
// tb/tb_vlog_word_checker.sv - table-driven bench for vlog_word_checker
module tb_vlog_word_checker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready, done, passed, timed_out;
    logic [7:0]  err_count;
    logic [1:0]  word_idx;
    logic [31:0] last_data;

    int n_tests = 0;
    int n_fail  = 0;

    vlog_word_checker #(
        .WIDTH(32), .NWORDS(3), .EXP0(42), .EXP1(66), .EXP2(77), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .done(done), .passed(passed), .timed_out(timed_out),
        .err_count(err_count), .word_idx(word_idx), .last_data(last_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [7:0]  exp_err;
        logic        exp_pass;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " in_ready"},  {31'd0, in_ready},  32'd0);
        check({tag, " done"},      {31'd0, done},      32'd0);
        check({tag, " passed"},    {31'd0, passed},    32'd0);
        check({tag, " timed_out"}, {31'd0, timed_out}, 32'd0);
        check({tag, " err_count"}, {24'd0, err_count}, 32'd0);
        check({tag, " word_idx"},  {30'd0, word_idx},  32'd0);
        check({tag, " last_data"}, last_data,          32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] w);
        check("ready before send", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{w0: 32'd42, w1: 32'd66, w2: 32'd77, exp_err: 8'd0, exp_pass: 1'b1};
        vecs[1] = '{w0: 32'd42, w1: 32'd65, w2: 32'd77, exp_err: 8'd1, exp_pass: 1'b0};
        vecs[2] = '{w0: 32'd42, w1: 32'bx,  w2: 32'd77, exp_err: 8'd1, exp_pass: 1'b0};
        vecs[3] = '{w0: 32'd0,  w1: 32'd0,  w2: 32'd0,  exp_err: 8'd3, exp_pass: 1'b0};
        vecs[4] = '{w0: 32'd42, w1: 32'd66, w2: 32'd78, exp_err: 8'd1, exp_pass: 1'b0};
        vecs[5] = '{w0: 32'd41, w1: 32'd66, w2: 32'd77, exp_err: 8'd1, exp_pass: 1'b0};

        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            send(vecs[i].w0);
            send(vecs[i].w1);
            check("not done after 2", {31'd0, done}, 32'd0);
            send(vecs[i].w2);
            in_valid = 1'b0;
            check("vec done",      {31'd0, done},      32'd1);
            check("vec passed",    {31'd0, passed},    {31'd0, vecs[i].exp_pass});
            check("vec err_count", {24'd0, err_count}, {24'd0, vecs[i].exp_err});
            check("vec timed_out", {31'd0, timed_out}, 32'd0);
            check("vec word_idx",  {30'd0, word_idx},  32'd3);
            check("vec last_data", last_data,          vecs[i].w2);
            check("vec in_ready",  {31'd0, in_ready},  32'd0);
        end

        // in_valid held after done: nothing more accepted
        in_valid = 1'b1;
        in_data  = 32'd99;
        repeat (3) @(negedge clk);
        check("post-done in_ready",  {31'd0, in_ready},  32'd0);
        check("post-done last_data", last_data,          32'd77);
        check("post-done err_count", {24'd0, err_count}, 32'd1);
        check("post-done word_idx",  {30'd0, word_idx},  32'd3);
        in_valid = 1'b0;

        // timeout after 16 idle cycles
        do_reset();
        send(32'd42);
        idle(15);
        check("to not yet done", {31'd0, done}, 32'd0);
        idle(1);
        check("to done",      {31'd0, done},      32'd1);
        check("to timed_out", {31'd0, timed_out}, 32'd1);
        check("to passed",    {31'd0, passed},    32'd0);
        check("to word_idx",  {30'd0, word_idx},  32'd1);
        check("to in_ready",  {31'd0, in_ready},  32'd0);

        // transfer on the 16th idle cycle beats the timeout
        do_reset();
        send(32'd42);
        idle(15);
        send(32'd66);
        in_valid = 1'b0;
        check("race done",      {31'd0, done},      32'd0);
        check("race timed_out", {31'd0, timed_out}, 32'd0);
        check("race word_idx",  {30'd0, word_idx},  32'd2);
        idle(15);
        check("race counter cleared", {31'd0, done}, 32'd0);
        idle(1);
        check("race second timeout", {31'd0, timed_out}, 32'd1);

        // reset mid-run clears asynchronously, then a clean run passes
        do_reset();
        send(32'd42);
        send(32'd99);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'd42);
        send(32'd66);
        send(32'd77);
        in_valid = 1'b0;
        check("rerun done",   {31'd0, done},      32'd1);
        check("rerun passed", {31'd0, passed},    32'd1);
        check("rerun err",    {24'd0, err_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
